imem_loader: RTL and testbench
==============================

# imem_loader

Program loader that fills the CPU's writable instruction memory from a byte stream, typically the UART receiver, so new programs run without re-synthesising the instruction store. It accepts a length-prefixed, big-endian byte stream, assembles 32-bit MIPS instruction words, and issues one write per word to the instruction memory write port. While loading, it holds the CPU in reset.

## Interface
Parameters:
- DATA_WIDTH, 32, instruction word width; must be 32.
- ADDR_WIDTH, 10, instruction memory word-address width; depth = 2^ADDR_WIDTH words.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load_start  in  1  single-cycle request to begin a load; honoured only in IDLE.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader can accept a byte; a byte transfers when in_valid && in_ready.
- mem_we  out  1  single-cycle instruction memory write strobe.
- mem_addr  out  ADDR_WIDTH  word address for the write.
- mem_wdata  out  DATA_WIDTH  word to write.
- busy  out  1  load in progress; drives CPU reset hold.
- done  out  1  single-cycle pulse when a load finishes.
- err  out  1  sticky error for the last load; cleared by the next load_start.

## Operation
- Stream format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4·N data bytes. First byte of each word lands in wdata[31:24].
- States: IDLE -> LEN_HI -> LEN_LO -> DATA -> (CSUM) -> DONE -> IDLE.
  - IDLE: in_ready=0. load_start moves to LEN_HI, sets busy, clears err, address counter, byte index and checksum.
  - LEN_HI / LEN_LO: each consumes one byte into the count register. After LEN_LO: N=0 goes to CSUM if compiled in, else DONE; otherwise DATA.
  - DATA: a 2-bit byte index shifts bytes into a word register. On the 4th byte, the next cycle issues mem_we=1 with mem_addr = word index and mem_wdata = the assembled word. The word index then increments. After word N, go to CSUM or DONE.
  - DONE: one cycle. done=1, busy falls the following cycle, return to IDLE.
- Overflow: a word index ≥ 2^ADDR_WIDTH suppresses mem_we, but the bytes are still consumed. err is set at DONE. The address never wraps.
- in_ready=1 in LEN_HI, LEN_LO, DATA and CSUM, including the cycle mem_we is asserted, so a full-rate stream is never stalled.
- load_start while busy is ignored. in_valid in IDLE is ignored, and no byte is consumed.
- Reset mid-load: all state returns to its reset value, the partial word is discarded, and no write is issued.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, state=IDLE.
- load_start at cycle t: busy=1 and in_ready=1 from t+1.
- Write latency: mem_we asserts exactly 1 cycle after the 4th byte of a word transfers. mem_addr and mem_wdata are valid only while mem_we=1 and hold their values afterwards.
- done asserts 1 cycle after the last consumed byte, or 1 cycle after the last mem_we if that is later. busy deasserts the cycle after done.
- All outputs are registered.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - CSUM state expects one trailing byte equal to the XOR of all 4·N data bytes; the length bytes are excluded.
  - On a mismatch, err=1 at DONE. The memory writes already issued are not undone.
- Undefined: CSUM state is absent, no trailing byte is consumed, and err reflects overflow only.

## Test plan
- Two words: start, bytes 00 02 20 11 00 01 08 00 0c 05 (plus 31 with checksum) -> mem_we at addr 0 = 20110001, at addr 1 = 08000c05; done pulse; err=0; busy high throughout.
- Zero length: start, bytes 00 00 (plus 00 with checksum) -> no mem_we, done pulse, err=0.
- Overflow with ADDR_WIDTH=2: N=5, 20 bytes -> exactly 4 writes at addresses 0..3; 5th word dropped; err=1 at done.
- Checksum enabled, wrong byte (32 instead of 31) in the two-word stream -> both writes occur; err=1; err cleared on next load_start.
- Reset mid-word: rst_n low after 2 data bytes -> all outputs 0 immediately, no write; a fresh load afterwards writes from addr 0 correctly.
- Backpressure/ignore: in_valid gaps of 0–3 cycles give the same writes; a load_start pulse while busy, and bytes sent in IDLE, cause no state change.

Source files
------------

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - length-prefixed byte stream to instruction memory loader
//
// Receives a big-endian 16-bit word count N followed by 4*N data bytes, packs
// each group of four bytes (first byte in bits [31:24]) into one instruction
// word and writes it to the instruction memory at consecutive word addresses.
// busy is held for the whole load so the CPU can be kept in reset meanwhile.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, one trailing byte equal to the XOR of all data bytes is
//   expected after the data; a mismatch sets err at the end of the load.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   load_start          start request, only honoured while idle
//   in_data/in_valid    input byte stream
//   in_ready            byte accepted on in_valid && in_ready
//   mem_we/mem_addr/mem_wdata  instruction memory write port (one strobe per word)
//   busy                load in progress
//   done                one-cycle pulse at end of load
//   err                 overflow (or checksum) error of the last load

module imem_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE
    } state_t;

    state_t      state, state_d;
    logic [15:0] len;
    logic [16:0] wcnt;       // words completed so far; wider than any address
    logic [1:0]  bidx;
    logic [23:0] word_sr;
    logic        ovf;
    logic        flush;      // cycle in which the final word's write is issued
    logic        flush_d;
    logic        in_ready_d;
    logic [7:0]  csum;

    logic xfer, len_zero, word_end, last_word, in_range, csum_miss;

    assign xfer      = in_valid && in_ready;
    assign len_zero  = ({len[15:8], in_data} == 16'd0);
    assign word_end  = (state == S_DATA) && xfer && (bidx == 2'd3);
    assign last_word = ((wcnt + 17'd1) == {1'b0, len});
    assign in_range  = ((wcnt >> ADDR_WIDTH) == 17'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign csum_miss = (state == S_CSUM) && xfer && (in_data != csum);
`else
    assign csum_miss = 1'b0;
`endif

    always_comb begin
        state_d = state;
        flush_d = 1'b0;
        case (state)
            S_IDLE:   if (load_start) state_d = S_LEN_HI;
            S_LEN_HI: if (xfer) state_d = S_LEN_LO;
            S_LEN_LO: begin
                if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = len_zero ? S_CSUM : S_DATA;
`else
                    state_d = len_zero ? S_DONE : S_DATA;
`endif
                end
            end
            S_DATA: begin
                if (flush) begin
                    state_d = S_DONE;
                end else if (word_end && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = S_CSUM;
`else
                    // A written final word needs its strobe cycle before done;
                    // a dropped one can finish straight away.
                    if (in_range) flush_d = 1'b1;
                    else          state_d = S_DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM:   if (xfer) state_d = S_DONE;
`endif
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                     ((state_d == S_DATA) && !flush_d);
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (state_d == S_CSUM) in_ready_d = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            flush     <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            len       <= '0;
            wcnt      <= '0;
            bidx      <= '0;
            word_sr   <= '0;
            ovf       <= 1'b0;
            csum      <= '0;
        end else begin
            state    <= state_d;
            flush    <= flush_d;
            in_ready <= in_ready_d;
            busy     <= (state_d != S_IDLE);
            done     <= (state_d == S_DONE);
            mem_we   <= 1'b0;

            if (state == S_IDLE && load_start) begin
                err  <= 1'b0;
                len  <= '0;
                wcnt <= '0;
                bidx <= '0;
                ovf  <= 1'b0;
                csum <= '0;
            end
            if (state == S_LEN_HI && xfer) len[15:8] <= in_data;
            if (state == S_LEN_LO && xfer) len[7:0]  <= in_data;

            if (state == S_DATA && xfer) begin
                bidx    <= bidx + 2'd1;
                word_sr <= {word_sr[15:0], in_data};
                csum    <= csum ^ in_data;
                if (bidx == 2'd3) begin
                    wcnt <= wcnt + 17'd1;
                    if (in_range) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= wcnt[ADDR_WIDTH-1:0];
                        mem_wdata <= {word_sr, in_data};
                    end else begin
                        ovf <= 1'b1;
                    end
                end
            end

            // Fold in errors detected on the very edge that enters DONE.
            if (state_d == S_DONE)
                err <= ovf | (word_end && !in_range) | csum_miss;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader

module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready, mem_we, busy, done, err;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    logic busy_at_done = 1'b0;
    logic err_at_done = 1'b0;
    logic [9:0]  wq_addr[$];
    logic [31:0] wq_data[$];
    logic [7:0]  two_q[$];

    imem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            wq_addr.push_back(mem_addr);
            wq_data.push_back(mem_wdata);
        end
        if (done) begin
            done_cnt++;
            busy_at_done = busy;
            err_at_done  = err;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int k;
        in_valid = 1'b0;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
        in_data  = b;
        in_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (k >= 20) begin
            errors++;
            $display("FAIL send_byte: in_ready stayed %0b for byte %h, required 1", in_ready, b);
        end
    endtask

    task automatic start_load();
        @(posedge clk);
        #1 load_start = 1'b1;
        @(posedge clk);
        #1 load_start = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL start: busy=%b in_ready=%b err=%b, required 1 1 0", busy, in_ready, err);
        end
    endtask

    task automatic wait_done(input string name, input int n0);
        int k = 0;
        while (done_cnt == n0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        #1;
        checks++;
        if (done_cnt != n0 + 1 || busy_at_done !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s done: pulses=%0d busy_at_done=%b busy=%b done=%b, required 1 1 0 0",
                     name, done_cnt - n0, busy_at_done, busy, done);
        end
    endtask

    task automatic check_two_writes(input string name);
        checks++;
        if (wq_addr.size() != 2) begin
            errors++;
            $display("FAIL %s writes: count=%0d, required 2", name, wq_addr.size());
        end else if (wq_addr[0] !== 10'd0 || wq_data[0] !== 32'h20110001 ||
                     wq_addr[1] !== 10'd1 || wq_data[1] !== 32'h08000c05) begin
            errors++;
            $display("FAIL %s writes: %0d=%h %0d=%h, required 0=20110001 1=08000c05",
                     name, wq_addr[0], wq_data[0], wq_addr[1], wq_data[1]);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, mem_we, busy, done, err} !== 5'b0 || mem_addr !== 10'd0 || mem_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset: ready,we,busy,done,err=%b addr=%h wdata=%h, required all 0",
                     {in_ready, mem_we, busy, done, err}, mem_addr, mem_wdata);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({in_ready, busy, done} !== 3'b0) begin
            errors++;
            $display("FAIL reset_release: ready,busy,done=%b, required 000", {in_ready, busy, done});
        end
    endtask

    task automatic test_two_words();
        int n0;
        wq_addr.delete(); wq_data.delete();
        n0 = done_cnt;
        start_load();
        foreach (two_q[i]) begin
            send_byte(two_q[i], 0);
            if (i == 5) begin
                checks++;
                if (mem_we !== 1'b1 || mem_addr !== 10'd0 || mem_wdata !== 32'h20110001) begin
                    errors++;
                    $display("FAIL latency: we=%b addr=%h wdata=%h, required 1 000 20110001",
                             mem_we, mem_addr, mem_wdata);
                end
            end
        end
        wait_done("two_words", n0);
        check_two_writes("two_words");
        checks++;
        if (err_at_done !== 1'b0) begin
            errors++;
            $display("FAIL two_words err: %b, required 0", err_at_done);
        end
    endtask

    task automatic test_overflow();
        int n0;
        logic [7:0] cs = 8'h00;
        logic [15:0] w;
        wq_addr.delete(); wq_data.delete();
        n0 = done_cnt;
        start_load();
        send_byte(8'h04, 0);
        send_byte(8'h01, 0);
        for (int i = 0; i < 1025; i++) begin
            w = 16'(i);
            send_byte(8'hc0, 0);
            send_byte(8'h00, 0);
            send_byte(w[15:8], 0);
            send_byte(w[7:0], 0);
            cs = cs ^ 8'hc0 ^ w[15:8] ^ w[7:0];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(cs, 0);
`endif
        wait_done("overflow", n0);
        checks++;
        if (wq_addr.size() != 1024) begin
            errors++;
            $display("FAIL overflow count: %0d, required 1024", wq_addr.size());
        end else if (wq_addr[0] !== 10'd0 || wq_data[0] !== 32'hc0000000 ||
                     wq_addr[1023] !== 10'd1023 || wq_data[1023] !== 32'hc00003ff) begin
            errors++;
            $display("FAIL overflow data: first %h=%h last %h=%h, required 000=c0000000 3ff=c00003ff",
                     wq_addr[0], wq_data[0], wq_addr[1023], wq_data[1023]);
        end
        checks++;
        if (err_at_done !== 1'b1 || err !== 1'b1) begin
            errors++;
            $display("FAIL overflow err: at_done=%b now=%b, required 1 1", err_at_done, err);
        end
    endtask

    task automatic test_zero_length();
        int n0;
        wq_addr.delete(); wq_data.delete();
        n0 = done_cnt;
        start_load();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h00, 0);
`endif
        wait_done("zero_length", n0);
        checks++;
        if (wq_addr.size() != 0 || err_at_done !== 1'b0) begin
            errors++;
            $display("FAIL zero_length: writes=%0d err=%b, required 0 0", wq_addr.size(), err_at_done);
        end
    endtask

    task automatic test_reset_mid_word();
        wq_addr.delete(); wq_data.delete();
        start_load();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hab, 0);
        send_byte(8'hcd, 0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, mem_we, busy, done, err} !== 5'b0 || mem_addr !== 10'd0 || mem_wdata !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset: ready,we,busy,done,err=%b addr=%h wdata=%h, required all 0",
                     {in_ready, mem_we, busy, done, err}, mem_addr, mem_wdata);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (wq_addr.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset writes: count=%0d busy=%b, required 0 0", wq_addr.size(), busy);
        end
        test_two_words();
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum_bad();
        int n0;
        wq_addr.delete(); wq_data.delete();
        n0 = done_cnt;
        start_load();
        for (int i = 0; i < 10; i++) send_byte(two_q[i], 0);
        send_byte(8'h32, 0);
        wait_done("checksum_bad", n0);
        check_two_writes("checksum_bad");
        checks++;
        if (err_at_done !== 1'b1 || err !== 1'b1) begin
            errors++;
            $display("FAIL checksum err: at_done=%b now=%b, required 1 1", err_at_done, err);
        end
        wq_addr.delete(); wq_data.delete();
        n0 = done_cnt;
        start_load();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        wait_done("checksum_recover", n0);
    endtask
`endif

    task automatic test_back_to_back();
        int n0;
        wq_addr.delete(); wq_data.delete();
        in_data  = 8'haa;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (in_ready !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_bytes: in_ready=%b busy=%b, required 0 0", in_ready, busy);
            end
        end
        in_valid = 1'b0;
        n0 = done_cnt;
        start_load();
        foreach (two_q[i]) begin
            if (i == 4) begin
                load_start = 1'b1;
                @(posedge clk);
                #1 load_start = 1'b0;
            end
            send_byte(two_q[i], i % 4);
        end
        wait_done("back_to_back", n0);
        check_two_writes("back_to_back");
        checks++;
        if (err_at_done !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back err: %b, required 0", err_at_done);
        end
    endtask

    initial begin
        two_q = '{8'h00, 8'h02, 8'h20, 8'h11, 8'h00, 8'h01, 8'h08, 8'h00, 8'h0c, 8'h05};
`ifdef IMEM_LOADER_CHECKSUM_EN
        two_q.push_back(8'h31);
`endif
        test_reset();
        test_two_words();
        test_overflow();
        test_zero_length();
        test_reset_mid_word();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum_bad();
`endif
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
